// File: rtl/systolic_array_sequencer_if.sv
// rtl/systolic_array_sequencer_if.sv - control/address bundle between the sequencer and its environment
// master = sequencer side, slave = buffers/array/result-FIFO side.
interface systolic_array_sequencer_if #(
  parameter int ROW   = 9,
  parameter int CNT_W = 9
);
  localparam int WA_W = (ROW > 1) ? $clog2(ROW) : 1;

  logic             start;
  logic [CNT_W-1:0] cfg_num_vec;
  logic             busy;
  logic             done;
  logic             wbuf_rd;
  logic [WA_W-1:0]  wbuf_addr;
  logic             sa_sel;
  logic             abuf_rd;
  logic [CNT_W-1:0] abuf_addr;
  logic             sa_west_valid;
  logic             res_valid;
  logic             res_pop;

  modport master (
    input  start, cfg_num_vec, res_pop,
    output busy, done, wbuf_rd, wbuf_addr, sa_sel,
           abuf_rd, abuf_addr, sa_west_valid, res_valid
  );

  modport slave (
    output start, cfg_num_vec, res_pop,
    input  busy, done, wbuf_rd, wbuf_addr, sa_sel,
           abuf_rd, abuf_addr, sa_west_valid, res_valid
  );
endinterface

// File: rtl/systolic_array_sequencer.sv
// rtl/systolic_array_sequencer.sv - weight-load / credit-gated stream / drain sequencer for the systolic array
// Drives only addresses and control; buffer data reaches the array through external glue.
module systolic_array_sequencer #(
  parameter int ROW       = 9,
  parameter int COL       = 16,
  parameter int CNT_W     = 9,
  parameter int RES_DEPTH = 8,
  parameter int PIPE_LAT  = ROW + COL
) (
  input logic                          in_clk,
  input logic                          in_rst_n,
  systolic_array_sequencer_if.master   bus
);
  localparam int WA_W = (ROW > 1) ? $clog2(ROW) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t              r_state;
  logic [CNT_W-1:0]    r_nvec;
  logic [CNT_W-1:0]    r_issued;
  logic [CNT_W-1:0]    r_credits;
  logic [WA_W-1:0]     r_wbuf_addr;
  logic                r_wbuf_rd;
  logic                r_sa_sel;
  logic                r_west_valid;
  logic                r_done;
  logic [PIPE_LAT-1:0] r_vpipe;

  logic                w_issue;
  logic                w_pop_ok;
  logic                w_pipe_empty;
  logic [CNT_W-1:0]    w_issued_nxt;

  // Issue depends only on registered state, so abuf_rd/abuf_addr never see a combinational input path.
  assign w_issue      = (r_state == S_STREAM) && (r_credits != '0) && (r_issued < r_nvec);
  assign w_pop_ok     = bus.res_pop && (r_credits != CNT_W'(RES_DEPTH));
  assign w_pipe_empty = !r_west_valid && (r_vpipe == '0);
  assign w_issued_nxt = r_issued + CNT_W'(1);

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      r_state      <= S_IDLE;
      r_nvec       <= '0;
      r_issued     <= '0;
      r_credits    <= CNT_W'(RES_DEPTH);
      r_wbuf_addr  <= '0;
      r_wbuf_rd    <= 1'b0;
      r_sa_sel     <= 1'b0;
      r_west_valid <= 1'b0;
      r_done       <= 1'b0;
      r_vpipe      <= '0;
    end else begin
      r_done       <= 1'b0;
      r_sa_sel     <= r_wbuf_rd;
      r_west_valid <= w_issue;
      r_vpipe      <= {r_vpipe[PIPE_LAT-2:0], r_west_valid};

      // A pop refused at full credits must not cancel a same-cycle issue.
      if (w_issue && !w_pop_ok) begin
        r_credits <= r_credits - CNT_W'(1);
      end else if (!w_issue && w_pop_ok) begin
        r_credits <= r_credits + CNT_W'(1);
      end

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_nvec      <= bus.cfg_num_vec;
            r_issued    <= '0;
            r_wbuf_rd   <= 1'b1;
            r_wbuf_addr <= '0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (r_wbuf_addr == WA_W'(ROW - 1)) begin
            r_wbuf_rd <= 1'b0;
            r_state   <= (r_nvec == '0) ? S_DRAIN : S_STREAM;
          end else begin
            r_wbuf_addr <= r_wbuf_addr + WA_W'(1);
          end
        end
        S_STREAM: begin
          if (w_issue) begin
            r_issued <= w_issued_nxt;
            if (w_issued_nxt == r_nvec) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pipe_empty) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = (r_state != S_IDLE);
  assign bus.done          = r_done;
  assign bus.wbuf_rd       = r_wbuf_rd;
  assign bus.wbuf_addr     = r_wbuf_addr;
  assign bus.sa_sel        = r_sa_sel;
  assign bus.abuf_rd       = w_issue;
  assign bus.abuf_addr     = r_issued;
  assign bus.sa_west_valid = r_west_valid;
  assign bus.res_valid     = r_vpipe[PIPE_LAT-1];
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// tb/tb_systolic_array_sequencer.sv - randomized bench against a cycle-timeline model of the sequencer
module tb_systolic_array_sequencer;
  localparam int ROW       = 9;
  localparam int COL       = 16;
  localparam int CNT_W     = 9;
  localparam int RES_DEPTH = 8;
  localparam int PIPE_LAT  = ROW + COL;
  localparam int HIST      = 32768;

  logic in_clk   = 1'b0;
  logic in_rst_n = 1'b0;

  systolic_array_sequencer_if #(.ROW(ROW), .CNT_W(CNT_W)) bus ();

  systolic_array_sequencer #(
    .ROW(ROW), .COL(COL), .CNT_W(CNT_W), .RES_DEPTH(RES_DEPTH), .PIPE_LAT(PIPE_LAT)
  ) dut (
    .in_clk  (in_clk),
    .in_rst_n(in_rst_n),
    .bus     (bus)
  );

  always #5 in_clk = ~in_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model: job timeline anchored at the start cycle, credit arithmetic, per-cycle west-valid history.
  bit m_busy, m_drain, m_done, m_issue, m_wrd_prev;
  int m_s, m_nvec, m_issued, m_credits;
  bit wv [HIST];

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit wv_at(input int c);
    if (c < 0) return 1'b0;
    return wv[c % HIST];
  endfunction

  function automatic bit in_flight(input int c);
    for (int k = c - PIPE_LAT; k <= c; k++) begin
      if (wv_at(k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit exp_wrd(input int c);
    return m_busy && (c >= m_s + 1) && (c <= m_s + ROW);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_drain = 0; m_done = 0; m_issue = 0; m_wrd_prev = 0;
    m_s = 0; m_nvec = 0; m_issued = 0; m_credits = RES_DEPTH;
    for (int k = 0; k < HIST; k++) wv[k] = 1'b0;
  endtask

  task automatic model_advance(input bit st, input int nv, input bit pop);
    bit prev_issue = m_issue;
    bit prev_wrd   = exp_wrd(cyc);
    bit was_busy   = m_busy;
    bit fin        = m_busy && m_drain && !in_flight(cyc);
    int inc        = (pop && m_credits < RES_DEPTH) ? 1 : 0;
    m_credits = m_credits - int'(prev_issue) + inc;
    if (prev_issue) begin
      m_issued++;
      if (m_issued == m_nvec) m_drain = 1;
    end
    if (m_busy && !m_drain && cyc == m_s + ROW && m_nvec == 0) m_drain = 1;
    m_done = fin;
    if (fin) m_busy = 0;
    if (!was_busy && st) begin
      m_busy = 1; m_s = cyc; m_nvec = nv % (1 << CNT_W); m_issued = 0; m_drain = 0;
    end
    m_wrd_prev = prev_wrd;
    cyc++;
    wv[cyc % HIST] = prev_issue;
    m_issue = m_busy && !m_drain && (cyc >= m_s + ROW + 1) && (m_credits > 0) && (m_issued < m_nvec);
  endtask

  task automatic compare_all();
    chk("busy",       int'(bus.busy),          int'(m_busy));
    chk("done",       int'(bus.done),          int'(m_done));
    chk("wbuf_rd",    int'(bus.wbuf_rd),       int'(exp_wrd(cyc)));
    if (exp_wrd(cyc)) chk("wbuf_addr", int'(bus.wbuf_addr), cyc - m_s - 1);
    chk("sa_sel",     int'(bus.sa_sel),        int'(m_wrd_prev));
    chk("abuf_rd",    int'(bus.abuf_rd),       int'(m_issue));
    chk("abuf_addr",  int'(bus.abuf_addr),     m_issued);
    chk("west_valid", int'(bus.sa_west_valid), int'(wv_at(cyc)));
    chk("res_valid",  int'(bus.res_valid),     int'(wv_at(cyc - PIPE_LAT)));
    chk("sel_wv_excl", int'(bus.sa_sel & bus.sa_west_valid), 0);
  endtask

  task automatic tick(input bit st, input int nv, input bit pop);
    bus.start       = st;
    bus.cfg_num_vec = nv[CNT_W-1:0];
    bus.res_pop     = pop;
    @(posedge in_clk);
    #1;
    model_advance(st, nv, pop);
    compare_all();
  endtask

  // mode 0: never pop, 1: pop every cycle, 2: random legal pops plus random ignored starts
  function automatic bit gen_pop(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return ($urandom_range(0, 1) == 1) && (m_credits < RES_DEPTH);
    return 1'b0;
  endfunction

  task automatic run_until_done(input int mode, input int budget);
    int ndone = int'(bus.done);
    for (int k = 0; k < budget && m_busy; k++) begin
      tick((mode == 2) && ($urandom_range(0, 7) == 0), $urandom_range(0, 40), gen_pop(mode));
      ndone += int'(bus.done);
    end
    chk("job_finished", int'(bus.busy), 0);
    chk("done_count",   ndone, 1);
  endtask

  task automatic run_job(input int nv, input int mode);
    tick(1'b1, nv, gen_pop(mode));
    run_until_done(mode, 4000);
  endtask

  task automatic do_reset(input int hold);
    bus.start   = 1'b1;
    bus.res_pop = 1'b0;
    in_rst_n    = 1'b0;
    #1;
    model_reset();
    compare_all();
    for (int k = 0; k < hold; k++) begin
      @(posedge in_clk);
      #1;
      compare_all();
    end
    in_rst_n  = 1'b1;
    bus.start = 1'b0;
  endtask

  initial begin
    bus.start = 1'b1; bus.cfg_num_vec = '0; bus.res_pop = 1'b0;
    model_reset();
    @(posedge in_clk);
    #1;
    do_reset(3);

    run_job(4, 1);

    tick(1'b1, 12, 1'b0);
    for (int k = 0; k < 50; k++) tick(1'b0, 0, 1'b0);
    for (int p = 0; p < 4; p++) begin
      tick(1'b0, 0, 1'b1);
      tick(1'b0, 0, 1'b0);
      tick(1'b0, 0, 1'b0);
    end
    run_until_done(0, 200);

    // Return the credits still held by the stalled job's results.
    for (int k = 0; k < RES_DEPTH; k++) tick(1'b0, 0, m_credits < RES_DEPTH);

    tick(1'b1, 0, 1'b0);
    for (int k = 0; k < 4; k++) tick(1'b1, 7, 1'b0);
    run_until_done(0, 200);

    tick(1'b1, 20, 1'b0);
    for (int k = 0; k < ROW + 7; k++) tick(1'b0, 0, 1'b0);
    run_until_done(1, 300);

    for (int k = 0; k < 3; k++) tick(1'b0, 0, 1'b1);

    tick(1'b1, 20, 1'b1);
    for (int k = 0; k < ROW + 5; k++) tick(1'b0, 0, 1'b1);
    do_reset(2);
    for (int k = 0; k < 3; k++) tick(1'b0, 0, 1'b0);
    run_job(4, 1);

    run_job(511, 1);

    for (int j = 0; j < 20; j++) begin
      int idle = $urandom_range(0, 3);
      for (int k = 0; k < idle; k++) tick(1'b0, 0, $urandom_range(0, 1) == 1);
      run_job($urandom_range(0, 40), 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
